// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: loads a parallel word, shifts it out one bit per clock, then a zero guard gap.
// Define SEQ_PATTERN_TX_PARITY_EN to append an even-parity bit (PAR state) after the data bits.
module seq_pattern_tx #(
    parameter int WIDTH     = 8,
    parameter int GAP       = 2,
    parameter int MSB_FIRST = 1,
    localparam int LW       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LW-1:0]    len,
    output logic             ready,
    output logic             out,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);
    // state: 00 IDLE waiting for load | 01 SEND data bits | 10 PAR parity bit | 11 GAP forced zeros
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_SEND = 2'b01;
    localparam logic [1:0] ST_PAR  = 2'b10;
    localparam logic [1:0] ST_GAP  = 2'b11;

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;
    localparam logic [1:0]    ST_TAIL  = (GAP > 0) ? ST_GAP : ST_IDLE;
    localparam logic [LW-1:0] LEN_MAX  = LW'(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic [LW-1:0]    n_q, n_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             out_q, out_d;
    logic             done_q, done_d;
    logic             par_q, par_d;

    logic [LW-1:0]    len_eff;
    logic [WIDTH-1:0] pat_masked;
    logic [WIDTH-1:0] pat_aligned;

    // MSB-first frames are left-aligned so the next bit is always the register's top bit.
    always_comb begin
        len_eff     = (len == '0 || len > LEN_MAX) ? LEN_MAX : len;
        pat_masked  = pattern & ~({WIDTH{1'b1}} << len_eff);
        pat_aligned = (MSB_FIRST != 0) ? (pat_masked << (LEN_MAX - len_eff)) : pat_masked;
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        gap_d   = gap_q;
        par_d   = par_q;
        out_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d = ST_SEND;
                    n_d     = len_eff;
                    cnt_d   = '0;
                    sr_d    = pat_aligned;
                    par_d   = ^pat_masked;
                    out_d   = (MSB_FIRST != 0) ? pat_aligned[WIDTH-1] : pat_aligned[0];
                end
            end
            ST_SEND: begin
                if (cnt_q == n_q - 1'b1) begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
                    state_d = ST_PAR;
                    out_d   = par_q;
`else
                    state_d = ST_TAIL;
                    done_d  = 1'b1;
                    gap_d   = GAP_LAST;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (MSB_FIRST != 0) begin
                        sr_d  = sr_q << 1;
                        out_d = sr_q[WIDTH-2];
                    end else begin
                        sr_d  = sr_q >> 1;
                        out_d = sr_q[1];
                    end
                end
            end
            ST_PAR: begin
                state_d = ST_TAIL;
                done_d  = 1'b1;
                gap_d   = GAP_LAST;
            end
            ST_GAP: begin
                if (gap_q == '0) state_d = ST_IDLE;
                else             gap_d   = gap_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            n_q     <= '0;
            gap_q   <= '0;
            par_q   <= 1'b0;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            gap_q   <= gap_d;
            par_q   <= par_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign ready = (state_q == ST_IDLE);
    assign busy  = (state_q != ST_IDLE);
    assign out   = out_q;
    assign done  = done_q;
    assign state = state_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: three instances (MSB-first gap 2, LSB-first gap 2, MSB-first gap 0).
module tb_seq_pattern_tx;
    localparam logic [1:0] IDLE = 2'b00, SEND = 2'b01, PAR = 2'b10, GAPS = 2'b11;
`ifdef SEQ_PATTERN_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] reset, load, ready, out, busy, done;
    logic [7:0] pattern [3];
    logic [3:0] len [3];
    logic [1:0] state [3];

    seq_pattern_tx #(.WIDTH(8), .GAP(2), .MSB_FIRST(1)) dut0 (
        .clk(clk), .reset(reset[0]), .load(load[0]), .pattern(pattern[0]), .len(len[0]),
        .ready(ready[0]), .out(out[0]), .busy(busy[0]), .done(done[0]), .state(state[0]));
    seq_pattern_tx #(.WIDTH(8), .GAP(2), .MSB_FIRST(0)) dut1 (
        .clk(clk), .reset(reset[1]), .load(load[1]), .pattern(pattern[1]), .len(len[1]),
        .ready(ready[1]), .out(out[1]), .busy(busy[1]), .done(done[1]), .state(state[1]));
    seq_pattern_tx #(.WIDTH(8), .GAP(0), .MSB_FIRST(1)) dut2 (
        .clk(clk), .reset(reset[2]), .load(load[2]), .pattern(pattern[2]), .len(len[2]),
        .ready(ready[2]), .out(out[2]), .busy(busy[2]), .done(done[2]), .state(state[2]));

    typedef struct {
        int         d;
        bit         o;
        logic [1:0] st;
        bit         dn;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, d, act, exp, $time);
        end
    endtask

    // Monitor: every entry queued for this cycle is compared against its instance.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out",   e.d, 32'(out[e.d]),   32'(e.o));
            chk("state", e.d, 32'(state[e.d]), 32'(e.st));
            chk("done",  e.d, 32'(done[e.d]),  32'(e.dn));
            chk("ready", e.d, 32'(ready[e.d]), 32'(e.st == IDLE));
            chk("busy",  e.d, 32'(busy[e.d]),  32'(e.st != IDLE));
        end
    end

    task automatic cyc(int d, bit ld, logic [7:0] pat, logic [3:0] ln, bit rst,
                       bit eo, logic [1:0] est, bit ed);
        load[d]    = ld;
        pattern[d] = pat;
        len[d]     = ln;
        reset[d]   = rst;
        @(posedge clk);
        #1;
        exp_q.push_back('{d, eo, est, ed});
    endtask

    // seq holds the expected serial order, first bit in seq[n-1]; par is the hand-computed parity.
    task automatic frame(int d, logic [7:0] pat, logic [3:0] ln, logic [7:0] seq, int n,
                         int gap, bit par, bit hold_ld);
        cyc(d, 1'b1, pat, ln, 1'b0, seq[n-1], SEND, 1'b0);
        for (int i = 1; i < n; i++)
            cyc(d, hold_ld, ~pat, 4'd1, 1'b0, seq[n-1-i], SEND, 1'b0);
        if (PAR_EN)
            cyc(d, hold_ld, ~pat, 4'd1, 1'b0, par, PAR, 1'b0);
        if (gap > 0) begin
            cyc(d, hold_ld, ~pat, 4'd1, 1'b0, 1'b0, GAPS, 1'b1);
            for (int i = 1; i < gap; i++)
                cyc(d, hold_ld, ~pat, 4'd1, 1'b0, 1'b0, GAPS, 1'b0);
            cyc(d, hold_ld, ~pat, 4'd1, 1'b0, 1'b0, IDLE, 1'b0);
        end else begin
            cyc(d, hold_ld, ~pat, 4'd1, 1'b0, 1'b0, IDLE, 1'b1);
        end
    endtask

    task automatic reset_all(bit ld);
        reset = 3'b111;
        load  = {3{ld}};
        for (int i = 0; i < 3; i++) begin
            pattern[i] = 8'hFF;
            len[i]     = 4'd0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) exp_q.push_back('{i, 1'b0, IDLE, 1'b0});
    endtask

    initial begin
        reset_all(1'b0);
        reset_all(1'b1);
        reset = 3'b000;
        load  = 3'b000;
        for (int i = 0; i < 3; i++) cyc(i, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, IDLE, 1'b0);

        // Full-length MSB-first frame, then short frames in both bit orders
        frame(0, 8'b1011_0110, 4'd0, 8'b1011_0110, 8, 2, 1'b1, 1'b0);
        cyc(0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, IDLE, 1'b0);
        frame(0, 8'b1111_0101, 4'd3, 8'b0000_0101, 3, 2, 1'b0, 1'b0);
        frame(1, 8'b1111_0101, 4'd3, 8'b0000_0101, 3, 2, 1'b0, 1'b0);
        frame(1, 8'b1011_0110, 4'd0, 8'b0110_1101, 8, 2, 1'b1, 1'b0);

        // Load held through the frame: ignored, single done
        frame(0, 8'hC3, 4'd0, 8'hC3, 8, 2, 1'b0, 1'b1);
        cyc(0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, IDLE, 1'b0);
        cyc(0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, IDLE, 1'b0);

        // Reset during the 4th bit abandons the frame
        cyc(0, 1'b1, 8'b1011_0110, 4'd0, 1'b0, 1'b1, SEND, 1'b0);
        cyc(0, 1'b0, 8'b1011_0110, 4'd0, 1'b0, 1'b0, SEND, 1'b0);
        cyc(0, 1'b0, 8'b1011_0110, 4'd0, 1'b0, 1'b1, SEND, 1'b0);
        cyc(0, 1'b0, 8'b1011_0110, 4'd0, 1'b0, 1'b1, SEND, 1'b0);
        cyc(0, 1'b0, 8'b1011_0110, 4'd0, 1'b1, 1'b0, IDLE, 1'b0);
        cyc(0, 1'b0, 8'b1011_0110, 4'd0, 1'b0, 1'b0, IDLE, 1'b0);
        frame(0, 8'b1011_0110, 4'd0, 8'b1011_0110, 8, 2, 1'b1, 1'b0);

        // Length boundaries: clamp above WIDTH, single bit, parity-0 pattern
        frame(0, 8'h3C, 4'd15, 8'h3C, 8, 2, 1'b0, 1'b0);
        frame(0, 8'h01, 4'd1, 8'h01, 1, 2, 1'b1, 1'b0);
        frame(0, 8'b0000_0011, 4'd0, 8'b0000_0011, 8, 2, 1'b0, 1'b0);

        // Zero gap with load held high: one IDLE cycle between frames
        frame(2, 8'hA5, 4'd0, 8'hA5, 8, 0, 1'b0, 1'b1);
        frame(2, 8'h0F, 4'd4, 8'h0F, 4, 0, 1'b0, 1'b1);
        frame(2, 8'h02, 4'd2, 8'h02, 2, 0, 1'b1, 1'b1);
        cyc(2, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, IDLE, 1'b0);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 0, 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
